// File: rtl/adder_nibble_sequencer_pkg.sv
// Shared constants for the nibble-serial adder: FSM state encoding and slice width.
package adder_nibble_sequencer_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADD  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int NIB_W = 4;

    function automatic int nibble_count(input int width);
        return width / NIB_W;
    endfunction

endpackage

// File: rtl/adder_nibble_sequencer_full_adder.sv
// Combinational 4-bit adder slice with carry-in and carry-out.
module full_adder_4bit (
    input  logic [3:0] A_i,
    input  logic [3:0] B_i,
    input  logic       C_i,
    output logic [3:0] S_o,
    output logic       C_o
);

    assign {C_o, S_o} = {1'b0, A_i} + {1'b0, B_i} + {4'b0000, C_i};

endmodule

// File: rtl/adder_nibble_sequencer.sv
// Multi-cycle WIDTH-bit adder: one 4-bit slice is reused for every nibble, LSB first,
// with the ripple carry held in a register between cycles.
module adder_nibble_sequencer
    import adder_nibble_sequencer_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] A_i,
    input  logic [WIDTH-1:0] B_i,
    input  logic             C_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] S_o,
    output logic             C_o,
    output logic             busy_o
);

    localparam int NIBBLES = nibble_count(WIDTH);
    localparam int CNT_W   = $clog2(NIBBLES) + 1;

    generate
        if ((WIDTH % NIB_W) != 0 || WIDTH < NIB_W) begin : g_width_check
            $error("adder_nibble_sequencer: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             carry_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] s_q;
    logic             c_q;
    logic             out_valid_q;

    int               nib_base;
    logic [NIB_W-1:0] a_nib;
    logic [NIB_W-1:0] b_nib;
    logic [NIB_W-1:0] slice_sum;
    logic             slice_carry;
    logic             last_nib;

    assign nib_base = NIB_W * int'(cnt);
    assign a_nib    = a_q[nib_base +: NIB_W];
    assign b_nib    = b_q[nib_base +: NIB_W];
    assign last_nib = (cnt == CNT_W'(NIBBLES - 1));

    full_adder_4bit u_slice (
        .A_i (a_nib),
        .B_i (b_nib),
        .C_i (carry_q),
        .S_o (slice_sum),
        .C_o (slice_carry)
    );

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values; the operand registers are reset too, keeping S_o/C_o at 0.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            s_q         <= '0;
            c_q         <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid_i) begin
                        a_q     <= A_i;
                        b_q     <= B_i;
                        carry_q <= C_i;
                        cnt     <= '0;
                        s_q     <= '0;
                        c_q     <= 1'b0;
                        state   <= ST_ADD;
                    end
                end
                ST_ADD: begin
                    s_q[nib_base +: NIB_W] <= slice_sum;
                    carry_q                <= slice_carry;
                    cnt                    <= cnt + CNT_W'(1);
                    if (last_nib) begin
                        c_q         <= slice_carry;
                        out_valid_q <= 1'b1;
                        state       <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready_o  = (state == ST_IDLE);
    assign busy_o      = (state == ST_ADD) || (state == ST_DONE);
    assign out_valid_o = out_valid_q;
    assign S_o         = s_q;
    assign C_o         = c_q;

endmodule
